branch_predict_ctrl: RTL and testbench
======================================

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- IDX_W, default 4, history-table index width (2^IDX_W entries).
- CNT_W, default 16, mispredict statistics counter width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_pc  in  32  fetch-stage PC.
- if_is_branch  in  1  fetch-stage predecode: instruction is a conditional branch.
- pred_taken  out  1  combinational prediction for the fetch-stage instruction.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_is_branch  in  1  execute instruction is a conditional branch.
- ex_pc  in  32  execute-stage PC.
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- ex_taken  in  1  resolved outcome from the branch condition unit.
- ex_target  in  32  computed branch target.
- redirect_valid  out  1  fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- flush  out  1  kill the IF/ID and ID/EX pipeline registers.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-003 SHALL hold a table of 2^IDX_W 2-bit saturating counters indexed by pc[IDX_W+1:2]; encodings 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-004 SHALL drive pred_taken = if_is_branch AND table[if_pc index][1], with zero latency.
REQ-005 SHALL consider a resolution only when ex_valid=1, ex_is_branch=1 and state=RUN.
REQ-006 On a considered resolution, SHALL update table[ex_pc index] at the next edge: increment (saturating at 11) if ex_taken=1, else decrement (saturating at 00).
REQ-007 SHALL define a mispredict as a considered resolution with ex_taken != ex_pred_taken.
REQ-008 On a mispredict, SHALL assert redirect_valid and flush combinationally in the same cycle.
REQ-009 On a mispredict, SHALL drive redirect_pc = ex_target if ex_taken=1, else ex_pc+4 (32-bit, wrapping modulo 2^32).
REQ-010 With no mispredict, redirect_valid and flush SHALL be 0 and redirect_pc SHALL be 0.
REQ-011 SHALL implement FSM states RUN and RECOVER:
- RUN -> RECOVER on a mispredict.
- RECOVER -> RUN unconditionally after one cycle.
- RUN -> RUN otherwise.
REQ-012 In RECOVER, SHALL ignore ex_* inputs: no table update, no redirect, no flush.
REQ-013 When lookup and update hit the same index in one cycle, pred_taken SHALL use the pre-update value (no bypass).
REQ-014 SHALL increment mispredict_cnt by 1 per mispredict, saturating at all-ones.
REQ-015 SHALL leave table and counter unchanged for non-branch or invalid ex slots.

Reset
REQ-016 While rst_n=0 at a rising edge, SHALL set every table entry to 01, state to RUN, and mispredict_cnt to 0.
REQ-017 While rst_n=0, redirect_valid and flush SHALL read 0 and pred_taken SHALL reflect the reset table.
REQ-018 Reset asserted during RECOVER SHALL return the FSM to RUN on that edge, with no residual flush.

Structure
REQ-019 SHALL take the counter encodings, FSM state enum and IDX_W default from a shared package, branch_pkg.
REQ-020 SHALL instantiate one sub-module, sat_counter2, implementing the 2-bit saturating next-value function.
REQ-021 The branch condition unit stays external; this block SHALL consume only its ex_taken result.

Verification
REQ-022 After reset, with if_is_branch=1 and if_pc=0x40, the bench SHALL check pred_taken=0.
REQ-023 With ex_pc=0x40, ex_pred_taken=0, ex_taken=1 and ex_target=0x100, the bench SHALL check flush=1 and redirect_pc=0x100 in the same cycle, state RECOVER on the next cycle, and entry 0 (index of 0x40) equal to 10.
REQ-024 With three consecutive taken resolutions at ex_pc=0x8 while pred_taken=1, the bench SHALL check the entry saturates at 11 and that no flush occurs.
REQ-025 With a mispredict followed immediately by a second mispredicting ex slot, the bench SHALL check the second is ignored (no flush, no update, count +1 only).
REQ-026 With ex_pred_taken=1, ex_taken=0 and ex_pc=0xFFFFFFFC, the bench SHALL check redirect_pc=0x00000000.
REQ-027 With CNT_W=2 and five mispredicts (RUN cycles between each), the bench SHALL check mispredict_cnt=3; reset asserted mid-RECOVER SHALL yield flush=0 and count=0.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared counter encodings, FSM states and default sizing for the branch predictor
// No ports; imported by sat_counter2 and branch_predict_ctrl.
package branch_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;
  localparam int IDX_W_DEF = 4;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter
// Ports: cur (present value), inc (1 = count up, 0 = count down), nxt (saturated next value).
module sat_counter2
  import branch_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);
  always_comb nxt = inc ? ((cur == ST) ? cur : cur + 2'd1) : ((cur == SNT) ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal branch predictor with mispredict redirect/flush and statistics
// Ports: clk/rst_n (sync active-low); if_pc/if_is_branch -> pred_taken (fetch lookup);
// ex_* resolution inputs -> redirect_valid/redirect_pc/flush; mispredict_cnt saturating count.
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  input  logic             if_is_branch,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);
  logic [1:0] tbl [2**IDX_W];
  state_t state, state_nxt;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [1:0] upd;
  logic considered, mis;
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  // lookup reads the registered table, so a same-cycle update is not bypassed
  assign pred_taken = if_is_branch & tbl[if_idx][1];
  // rst_n gating keeps redirect/flush quiet while reset is held
  assign considered = rst_n & ex_valid & ex_is_branch & (state == RUN);
  assign mis = considered & (ex_taken != ex_pred_taken);
  sat_counter2 u_sat (.cur(tbl[ex_idx]), .inc(ex_taken), .nxt(upd));
  always_comb begin
    state_nxt = (state == RUN && mis) ? RECOVER : RUN;
    redirect_valid = mis;
    flush = mis;
    redirect_pc = mis ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= WNT;
      state <= RUN;
      mispredict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (considered) tbl[ex_idx] <= upd;
      if (mis && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed self-checking bench for branch_predict_ctrl
module tb_branch_predict_ctrl;
  import branch_pkg::*;
  logic clk = 0, rst_n = 0;
  logic [31:0] if_pc = 0, ex_pc = 0, ex_target = 0;
  logic if_is_branch = 0, ex_valid = 0, ex_is_branch = 0, ex_pred_taken = 0, ex_taken = 0;
  logic pred_taken, redirect_valid, flush, pred_taken2, redirect_valid2, flush2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  branch_predict_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_is_branch(if_is_branch), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_target(ex_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .mispredict_cnt(cnt)
  );
  branch_predict_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_is_branch(if_is_branch), .pred_taken(pred_taken2),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_target(ex_target), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .flush(flush2), .mispredict_cnt(cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic br, input logic [31:0] pc, input logic pt, input logic tk, input logic [31:0] tg);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_pred_taken = pt; ex_taken = tk; ex_target = tg;
    #1;
  endtask
  initial begin
    step(); step();
    check("rst_state", dut.state, RUN);
    check("rst_cnt", cnt, 0);
    check("rst_tbl0", dut.tbl[0], 2'b01);
    ex(1, 1, 32'h40, 0, 1, 32'h100);
    check("rst_flush", flush, 0);
    check("rst_redir_v", redirect_valid, 0);
    if_is_branch = 1; if_pc = 32'h40; #1;
    check("rst_pred", pred_taken, 0);
    ex(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    step();
    check("pred_0x40", pred_taken, 0);
    ex(1, 1, 32'h40, 0, 1, 32'h100);
    check("mis1_flush", flush, 1);
    check("mis1_redir_v", redirect_valid, 1);
    check("mis1_redir_pc", redirect_pc, 32'h100);
    check("mis1_no_bypass", pred_taken, 0);
    step();
    check("mis1_state", dut.state, RECOVER);
    check("mis1_tbl0", dut.tbl[0], 2'b10);
    check("mis1_cnt", cnt, 1);
    check("mis1_pred_after", pred_taken, 1);
    check("rec_flush", flush, 0);
    check("rec_redir_v", redirect_valid, 0);
    check("rec_redir_pc", redirect_pc, 0);
    step();
    check("rec_state_run", dut.state, RUN);
    check("rec_tbl0", dut.tbl[0], 2'b10);
    check("rec_cnt", cnt, 1);
    if_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      ex(1, 1, 32'h8, 1, 1, 32'h200);
      check("sat_flush", flush, 0);
      check("sat_redir_pc", redirect_pc, 0);
      step();
    end
    check("sat_tbl2", dut.tbl[2], 2'b11);
    check("sat_pred", pred_taken, 1);
    check("sat_cnt", cnt, 1);
    ex(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h300);
    check("wrap_flush", flush, 1);
    check("wrap_redir_pc", redirect_pc, 32'h0);
    step();
    check("wrap_tbl15", dut.tbl[15], 2'b00);
    check("wrap_cnt", cnt, 2);
    ex(0, 0, 0, 0, 0, 0);
    step();
    ex(1, 0, 32'h40, 1, 0, 32'h0);
    check("nobr_flush", flush, 0);
    step();
    ex(0, 1, 32'h40, 1, 0, 32'h0);
    check("inv_flush", flush, 0);
    step();
    check("inv_tbl0", dut.tbl[0], 2'b10);
    check("inv_cnt", cnt, 2);
    for (int i = 0; i < 3; i++) begin
      ex(1, 1, 32'h20, 0, 1, 32'h400);
      check("loop_flush", flush, 1);
      step();
      ex(0, 0, 0, 0, 0, 0);
      step();
    end
    check("cnt16_five", cnt, 5);
    check("cnt2_sat", cnt2, 3);
    ex(1, 1, 32'h40, 0, 1, 32'h100);
    step();
    check("pre_rst_state", dut.state, RECOVER);
    rst_n = 0; #1;
    check("rstrec_flush_now", flush, 0);
    step();
    check("rstrec_state", dut.state, RUN);
    check("rstrec_flush", flush2, 0);
    check("rstrec_cnt2", cnt2, 0);
    check("rstrec_cnt", cnt, 0);
    check("rstrec_tbl0", dut.tbl[0], 2'b01);
    ex(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    step();
    check("post_rst_flush", flush, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
